corelet_ctrl: RTL and testbench

CORELET_CTRL -- requirements
Module: corelet_ctrl

---
 rtl/corelet_pkg.sv | 33 +++
 rtl/ctrl_cnt.sv | 29 ++
 rtl/corelet_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_corelet_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/corelet_pkg.sv
// Shared types and constants for the corelet controller: state encoding,
// instruction-bus bit positions and default array/tile geometry.
package corelet_pkg;

    localparam int unsigned ROW_DEF  = 8;
    localparam int unsigned COL_DEF  = 8;
    localparam int unsigned LEN_DEF  = 36;
    localparam int unsigned NKIJ_DEF = 9;
    localparam int unsigned AW_DEF   = 11;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned INST_W = 35;

    localparam int unsigned INST_LOAD     = 0;
    localparam int unsigned INST_EXEC     = 1;
    localparam int unsigned INST_L0_WR    = 2;
    localparam int unsigned INST_L0_RD    = 3;
    localparam int unsigned INST_OFIFO_RD = 6;
    localparam int unsigned INST_ACC      = 33;
    localparam int unsigned INST_RELU     = 34;

    typedef enum logic [2:0] {
        IDLE,
        W_L0,
        W_LOAD,
        X_L0,
        EXEC,
        DRAIN,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/ctrl_cnt.sv
// Loadable up-counter with a combinational terminal-count flag (cnt == last).
module ctrl_cnt
    import corelet_pkg::*;
#(
    parameter int unsigned w = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [w-1:0] din,
    input  logic [w-1:0] last,
    output logic [w-1:0] cnt,
    output logic         tc_c
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= din;
        end else if (en) begin
            cnt <= cnt + w'(1);
        end
    end

    assign tc_c = (cnt == last);

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet tile sequencer: weight load, activation load, execute, psum drain
// per kernel position, then accumulate. CORELET_CTRL_RELU_EN adds relu on acc.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int unsigned row  = ROW_DEF,
    parameter int unsigned col  = COL_DEF,
    parameter int unsigned len  = LEN_DEF,
    parameter int unsigned nkij = NKIJ_DEF,
    parameter int unsigned aw   = AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_o_valid,
    output logic [INST_W-1:0] inst,
    output logic              act_cen,
    output logic              w_cen,
    output logic              psum_cen,
    output logic              psum_wen,
    output logic [aw-1:0]     act_addr,
    output logic [aw-1:0]     w_addr,
    output logic [aw-1:0]     psum_addr,
    output logic              busy,
    output logic              done
);

    state_t state, state_n;

    logic [CNT_W-1:0] ph, rcnt, kij, ph_last;
    logic ph_tc_c, rcnt_tc_c, kij_tc_c;
    logic ph_load, ph_en, rcnt_load, rcnt_en, kij_load, kij_en;

    logic [INST_W-1:0] inst_n;
    logic act_cen_n, w_cen_n, psum_cen_n, psum_wen_n, busy_n, done_n;
    logic [aw-1:0] act_addr_n, w_addr_n, psum_addr_n;

    ctrl_cnt #(.w(CNT_W)) u_ph (
        .clk(clk), .reset(reset), .load(ph_load), .en(ph_en),
        .din('0), .last(ph_last), .cnt(ph), .tc_c(ph_tc_c)
    );

    ctrl_cnt #(.w(CNT_W)) u_rcnt (
        .clk(clk), .reset(reset), .load(rcnt_load), .en(rcnt_en),
        .din('0), .last(CNT_W'(len - 1)), .cnt(rcnt), .tc_c(rcnt_tc_c)
    );

    ctrl_cnt #(.w(CNT_W)) u_kij (
        .clk(clk), .reset(reset), .load(kij_load), .en(kij_en),
        .din('0), .last(CNT_W'(nkij - 1)), .cnt(kij), .tc_c(kij_tc_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, counter controls and next-cycle output values.
    always_comb begin
        state_n     = state;
        ph_en       = 1'b1;
        ph_load     = 1'b0;
        ph_last     = '0;
        rcnt_load   = 1'b0;
        rcnt_en     = 1'b0;
        kij_load    = 1'b0;
        kij_en      = 1'b0;
        inst_n      = '0;
        act_cen_n   = 1'b1;
        w_cen_n     = 1'b1;
        psum_cen_n  = 1'b1;
        psum_wen_n  = 1'b1;
        act_addr_n  = '0;
        w_addr_n    = '0;
        psum_addr_n = '0;
        busy_n      = (state != IDLE);
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                ph_en = 1'b0;
                if (start) begin
                    state_n  = W_L0;
                    kij_load = 1'b1;
                end
            end
            W_L0: begin
                ph_last            = CNT_W'(col - 1);
                w_cen_n            = 1'b0;
                w_addr_n           = aw'(32'(kij) * col + 32'(ph));
                inst_n[INST_L0_WR] = 1'b1;
                if (ph_tc_c) state_n = W_LOAD;
            end
            W_LOAD: begin
                ph_last = CNT_W'(col + row - 1);
                if (32'(ph) < col) begin
                    inst_n[INST_L0_RD] = 1'b1;
                    inst_n[INST_LOAD]  = 1'b1;
                end
                if (ph_tc_c) state_n = X_L0;
            end
            X_L0: begin
                ph_last            = CNT_W'(len - 1);
                act_cen_n          = 1'b0;
                act_addr_n         = aw'(ph);
                inst_n[INST_L0_WR] = 1'b1;
                if (ph_tc_c) state_n = EXEC;
            end
            EXEC: begin
                ph_last            = CNT_W'(len - 1);
                rcnt_load          = 1'b1;
                inst_n[INST_L0_RD] = 1'b1;
                inst_n[INST_EXEC]  = 1'b1;
                if (ph_tc_c) state_n = DRAIN;
            end
            DRAIN: begin
                // Progress only on valid OFIFO rows; no timeout by design.
                ph_en = 1'b0;
                if (ofifo_o_valid) begin
                    inst_n[INST_OFIFO_RD] = 1'b1;
                    psum_cen_n            = 1'b0;
                    psum_wen_n            = 1'b0;
                    psum_addr_n           = aw'(32'(kij) * len + 32'(rcnt));
                    rcnt_en               = 1'b1;
                    if (rcnt_tc_c) begin
                        kij_en  = 1'b1;
                        state_n = kij_tc_c ? ACC : W_L0;
                    end
                end
            end
            ACC: begin
                ph_last          = CNT_W'(len * nkij - 1);
                psum_cen_n       = 1'b0;
                psum_addr_n      = aw'(ph);
                inst_n[INST_ACC] = 1'b1;
`ifdef CORELET_CTRL_RELU_EN
                inst_n[INST_RELU] = 1'b1;
`endif
                if (ph_tc_c) state_n = DONE;
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state || state == IDLE) ph_load = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst      <= '0;
            act_cen   <= 1'b1;
            w_cen     <= 1'b1;
            psum_cen  <= 1'b1;
            psum_wen  <= 1'b1;
            act_addr  <= '0;
            w_addr    <= '0;
            psum_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            inst      <= inst_n;
            act_cen   <= act_cen_n;
            w_cen     <= w_cen_n;
            psum_cen  <= psum_cen_n;
            psum_wen  <= psum_wen_n;
            act_addr  <= act_addr_n;
            w_addr    <= w_addr_n;
            psum_addr <= psum_addr_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: a procedural tile script predicts every output cycle
// while OFIFO valid and stray start pulses are randomised.
module tb_corelet_ctrl;

    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int LEN  = 36;
    localparam int NKIJ = 9;
    localparam int AW   = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ofifo_o_valid;
    logic [34:0]   inst;
    logic          act_cen, w_cen, psum_cen, psum_wen, busy, done;
    logic [AW-1:0] act_addr, w_addr, psum_addr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [34:0]   inst;
        logic          act_cen, w_cen, psum_cen, psum_wen, busy, done;
        logic [AW-1:0] act_addr, w_addr, psum_addr;
        logic          addr_all;
    } exp_t;

    corelet_ctrl #(.row(ROW), .col(COL), .len(LEN), .nkij(NKIJ), .aw(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_o_valid(ofifo_o_valid),
        .inst(inst), .act_cen(act_cen), .w_cen(w_cen), .psum_cen(psum_cen),
        .psum_wen(psum_wen), .act_addr(act_addr), .w_addr(w_addr),
        .psum_addr(psum_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic is_busy);
        exp_t e;
        e.inst = '0;
        e.act_cen = 1'b1; e.w_cen = 1'b1; e.psum_cen = 1'b1; e.psum_wen = 1'b1;
        e.busy = is_busy; e.done = 1'b0;
        e.act_addr = '0; e.w_addr = '0; e.psum_addr = '0;
        e.addr_all = !is_busy;
        return e;
    endfunction

    task automatic cmp(input exp_t e);
        check("inst", 64'(inst), 64'(e.inst));
        check("act_cen", 64'(act_cen), 64'(e.act_cen));
        check("w_cen", 64'(w_cen), 64'(e.w_cen));
        check("psum_cen", 64'(psum_cen), 64'(e.psum_cen));
        check("psum_wen", 64'(psum_wen), 64'(e.psum_wen));
        check("busy", 64'(busy), 64'(e.busy));
        check("done", 64'(done), 64'(e.done));
        if (e.addr_all || !e.act_cen) check("act_addr", 64'(act_addr), 64'(e.act_addr));
        if (e.addr_all || !e.w_cen) check("w_addr", 64'(w_addr), 64'(e.w_addr));
        if (e.addr_all || (!e.psum_cen && !e.psum_wen))
            check("psum_addr", 64'(psum_addr), 64'(e.psum_addr));
    endtask

    task automatic cyc(input exp_t e);
        @(posedge clk);
        #1;
        cmp(e);
    endtask

    task automatic rand_in();
        start         = 1'($urandom_range(0, 1));
        ofifo_o_valid = 1'($urandom_range(0, 1));
    endtask

    // mode 0: valid held high, 1: valid toggles, 2: random valid.
    task automatic run_tile(input int mode, input int abort_kij, input int abort_c);
        exp_t e;
        logic tog;
        int   r;
        start = 1'b1;
        cyc(mk(1'b0));
        for (int k = 0; k < NKIJ; k++) begin
            for (int c = 0; c < COL; c++) begin
                rand_in();
                e = mk(1'b1); e.w_cen = 1'b0; e.w_addr = AW'(k * COL + c); e.inst[2] = 1'b1;
                cyc(e);
            end
            for (int c = 0; c < COL + ROW; c++) begin
                rand_in();
                e = mk(1'b1);
                if (c < COL) begin e.inst[3] = 1'b1; e.inst[0] = 1'b1; end
                cyc(e);
            end
            for (int c = 0; c < LEN; c++) begin
                rand_in();
                e = mk(1'b1); e.act_cen = 1'b0; e.act_addr = AW'(c); e.inst[2] = 1'b1;
                cyc(e);
            end
            for (int c = 0; c < LEN; c++) begin
                rand_in();
                if (k == abort_kij && c == abort_c) begin
                    #1 reset = 1'b0;
                    #1 cmp(mk(1'b0));
                    @(posedge clk);
                    #1 cmp(mk(1'b0));
                    start = 1'b0;
                    reset = 1'b1;
                    @(posedge clk);
                    #1 cmp(mk(1'b0));
                    return;
                end
                e = mk(1'b1); e.inst[3] = 1'b1; e.inst[1] = 1'b1;
                cyc(e);
            end
            r = 0;
            tog = 1'b1;
            while (r < LEN) begin
                rand_in();
                if (mode == 0) ofifo_o_valid = 1'b1;
                else if (mode == 1) begin ofifo_o_valid = tog; tog = !tog; end
                e = mk(1'b1);
                if (ofifo_o_valid) begin
                    e.inst[6] = 1'b1; e.psum_cen = 1'b0; e.psum_wen = 1'b0;
                    e.psum_addr = AW'(k * LEN + r);
                    r++;
                end
                cyc(e);
            end
        end
        for (int i = 0; i < LEN * NKIJ; i++) begin
            rand_in();
            e = mk(1'b1); e.psum_cen = 1'b0; e.psum_wen = 1'b1; e.inst[33] = 1'b1;
`ifdef CORELET_CTRL_RELU_EN
            e.inst[34] = 1'b1;
`endif
            cyc(e);
        end
        rand_in();
        e = mk(1'b1); e.done = 1'b1;
        cyc(e);
        start = 1'b0;
        cyc(mk(1'b0));
        cyc(mk(1'b0));
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ofifo_o_valid = 1'b0;
        #12 cmp(mk(1'b0));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1 cmp(mk(1'b0));

        run_tile(0, -1, 0);
        run_tile(1, -1, 0);
        run_tile(2, 4, int'($urandom_range(0, LEN - 1)));
        run_tile(2, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
